// File: rtl/cc_chan_pkg.sv
// -----------------------------------------------------------------------------
// cc_chan_pkg
// Shared types and helpers for the cc_chan_ctrl channel arbiter.
//   cc_chan_state_t : controller FSM states (IDLE, GRANT, BCAST, RECOVER)
//   CC_NCH_DEF      : default channel count
//   CC_HOLD_W_DEF   : default width of the grant-length counter
//   cc_bcast_mode() : broadcast-mode decode from the i/k/q mode pins
// -----------------------------------------------------------------------------
package cc_chan_pkg;

    localparam int CC_NCH_DEF    = 5;
    localparam int CC_HOLD_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BCAST   = 2'd2,
        RECOVER = 2'd3
    } cc_chan_state_t;

    // Broadcast mode is selected by i=1, k=1, q=0; anything else arbitrates.
    function automatic logic cc_bcast_mode(input logic i, input logic k, input logic q);
        return i & k & ~q;
    endfunction

endpackage

// File: rtl/cc_rr_arb.sv
// -----------------------------------------------------------------------------
// cc_rr_arb
// Purely combinational round-robin picker. The search starts at last+1
// (mod NCH) and returns the first requesting channel.
//   req  [NCH-1:0] : request vector
//   last [IW-1:0]  : index of the previous owner
//   gnt  [NCH-1:0] : one-hot winner (all zero when no request)
//   idx  [IW-1:0]  : index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module cc_rr_arb #(
    parameter int NCH = 5,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);

    logic          found_s;
    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;

    // Rotating priority search; the sum is one bit wider so the wrap is exact.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_s = {1'b0, last} + (IW+1)'(i) + (IW+1)'(1);
            if (sum_s >= (IW+1)'(NCH)) begin
                sum_s = sum_s - (IW+1)'(NCH);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IW-1:0];
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/cc_chan_ctrl.sv
// -----------------------------------------------------------------------------
// cc_chan_ctrl
// Registered channel-enable controller: fair round-robin single grant in
// arbitrated mode, one-cycle masked multi-grant in broadcast mode, and one
// dead RECOVER cycle after every grant so owners never touch.
// Ports:
//   pclk, prstn         : clock, asynchronous active-low reset
//   pm                  : master enable (gates new grants only)
//   pi, pk, pq          : mode decode, broadcast = pi & pk & ~pq
//   preq [NCH-1:0]      : level requests
//   pmask [NCH-1:0]     : broadcast permit
//   phold [HOLD_W-1:0]  : grant length, sampled at grant, 0 treated as 1
//   pdone               : release from current owner (ignored outside GRANT)
//   pgnt [NCH-1:0]      : registered grant vector
//   pgnt_vld            : registered |pgnt
//   pbusy               : FSM not in IDLE
//   pcnt [HOLD_W-1:0]   : remaining hold cycles, 0 outside GRANT
// Configuration macro: CC_CHAN_TIMEOUT_EN -- when defined, a grant is also
// released once its hold count expires.
// -----------------------------------------------------------------------------
module cc_chan_ctrl
    import cc_chan_pkg::*;
#(
    parameter int NCH    = CC_NCH_DEF,
    parameter int HOLD_W = CC_HOLD_W_DEF
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              pm,
    input  logic              pi,
    input  logic              pk,
    input  logic              pq,
    input  logic [NCH-1:0]    preq,
    input  logic [NCH-1:0]    pmask,
    input  logic [HOLD_W-1:0] phold,
    input  logic              pdone,
    output logic [NCH-1:0]    pgnt,
    output logic              pgnt_vld,
    output logic              pbusy,
    output logic [HOLD_W-1:0] pcnt
);

    localparam int IW = $clog2(NCH);

    cc_chan_state_t    state_r;
    logic [IW-1:0]     last_r;
    logic [IW-1:0]     win_idx_r;

    logic [NCH-1:0]    arb_gnt_s;
    logic [IW-1:0]     arb_idx_s;
    logic              bcast_s;
    logic [NCH-1:0]    bcast_vec_s;
    logic [HOLD_W-1:0] hold_load_s;
    logic              owner_drop_s;
    logic              timeout_s;
    logic              grant_exit_s;

    cc_rr_arb #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req  (preq),
        .last (last_r),
        .gnt  (arb_gnt_s),
        .idx  (arb_idx_s)
    );

    // Grant-length counter expiry; the last counted cycle is pcnt==1.
`ifdef CC_CHAN_TIMEOUT_EN
    assign timeout_s = (pcnt <= HOLD_W'(1));
`else
    assign timeout_s = 1'b0;
`endif

    // Entry and exit decode for the FSM.
    always_comb begin
        bcast_s     = cc_bcast_mode(pi, pk, pq);
        bcast_vec_s = preq & pmask;
        if (phold == '0) begin
            hold_load_s = HOLD_W'(1);
        end else begin
            hold_load_s = phold;
        end
        // pgnt holds exactly the winner while in GRANT, so this is the winner's request.
        owner_drop_s = ~|(preq & pgnt);
        grant_exit_s = pdone | owner_drop_s | timeout_s;
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_r   <= IDLE;
            last_r    <= IW'(NCH - 1);
            win_idx_r <= '0;
            pgnt      <= '0;
            pgnt_vld  <= 1'b0;
            pbusy     <= 1'b0;
            pcnt      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pm && bcast_s && (|bcast_vec_s)) begin
                        state_r  <= BCAST;
                        pgnt     <= bcast_vec_s;
                        pgnt_vld <= 1'b1;
                        pbusy    <= 1'b1;
                        pcnt     <= '0;
                    end else if (pm && (|preq)) begin
                        state_r   <= GRANT;
                        win_idx_r <= arb_idx_s;
                        pgnt      <= arb_gnt_s;
                        pgnt_vld  <= 1'b1;
                        pbusy     <= 1'b1;
                        pcnt      <= hold_load_s;
                    end else begin
                        state_r  <= IDLE;
                        pgnt     <= '0;
                        pgnt_vld <= 1'b0;
                        pbusy    <= 1'b0;
                        pcnt     <= '0;
                    end
                end
                GRANT: begin
                    if (grant_exit_s) begin
                        // Single exit point, so last updates once even if causes coincide.
                        state_r  <= RECOVER;
                        last_r   <= win_idx_r;
                        pgnt     <= '0;
                        pgnt_vld <= 1'b0;
                        pbusy    <= 1'b1;
                        pcnt     <= '0;
                    end else begin
                        state_r <= GRANT;
                        if (pcnt != '0) begin
                            pcnt <= pcnt - HOLD_W'(1);
                        end else begin
                            pcnt <= '0;
                        end
                    end
                end
                BCAST: begin
                    state_r  <= RECOVER;
                    pgnt     <= '0;
                    pgnt_vld <= 1'b0;
                    pbusy    <= 1'b1;
                    pcnt     <= '0;
                end
                RECOVER: begin
                    state_r  <= IDLE;
                    pgnt     <= '0;
                    pgnt_vld <= 1'b0;
                    pbusy    <= 1'b0;
                    pcnt     <= '0;
                end
                default: begin
                    state_r  <= IDLE;
                    pgnt     <= '0;
                    pgnt_vld <= 1'b0;
                    pbusy    <= 1'b0;
                    pcnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_chan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cc_chan_ctrl
// Self-checking bench for cc_chan_ctrl (NCH=5, HOLD_W=4). Each cycle's
// expected outputs are queued as the stimulus is applied and compared after
// the following rising edge. Hold-timeout cases follow CC_CHAN_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_cc_chan_ctrl;

    logic       pclk;
    logic       prstn;
    logic       pm;
    logic       pi;
    logic       pk;
    logic       pq;
    logic [4:0] preq;
    logic [4:0] pmask;
    logic [3:0] phold;
    logic       pdone;
    logic [4:0] pgnt;
    logic       pgnt_vld;
    logic       pbusy;
    logic [3:0] pcnt;

    typedef struct {
        string      name;
        logic [4:0] gnt;
        logic       busy;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    cc_chan_ctrl #(
        .NCH    (5),
        .HOLD_W (4)
    ) dut (
        .pclk     (pclk),
        .prstn    (prstn),
        .pm       (pm),
        .pi       (pi),
        .pk       (pk),
        .pq       (pq),
        .preq     (preq),
        .pmask    (pmask),
        .phold    (phold),
        .pdone    (pdone),
        .pgnt     (pgnt),
        .pgnt_vld (pgnt_vld),
        .pbusy    (pbusy),
        .pcnt     (pcnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected outputs for the coming edge, clock, then compare.
    task automatic step(input string name, input logic [4:0] g, input logic b, input logic [3:0] c);
        exp_t e;
        e.name = name;
        e.gnt  = g;
        e.busy = b;
        e.cnt  = c;
        sb_q.push_back(e);
        @(posedge pclk);
        #1;
        e = sb_q.pop_front();
        check_val({e.name, ".pgnt"},     32'(pgnt),     32'(e.gnt));
        check_val({e.name, ".pgnt_vld"}, 32'(pgnt_vld), 32'(|e.gnt));
        check_val({e.name, ".pbusy"},    32'(pbusy),    32'(e.busy));
        check_val({e.name, ".pcnt"},     32'(pcnt),     32'(e.cnt));
    endtask

    initial begin
        logic [4:0] one_hot;
        prstn = 1'b0;
        pm    = 1'b0;
        pi    = 1'b0;
        pk    = 1'b0;
        pq    = 1'b0;
        preq  = 5'b00000;
        pmask = 5'b11111;
        phold = 4'd15;
        pdone = 1'b0;
        #12;
        check_val("rst.pgnt",     32'(pgnt),     32'd0);
        check_val("rst.pgnt_vld", 32'(pgnt_vld), 32'd0);
        check_val("rst.pbusy",    32'(pbusy),    32'd0);
        check_val("rst.pcnt",     32'(pcnt),     32'd0);
        @(negedge pclk);
        prstn = 1'b1;

        // Basic arbitration: channel 1 first (search starts at 0), then 2.
        pm   = 1'b1;
        preq = 5'b10110;
        step("arb1",   5'b00010, 1'b1, 4'd15);
        step("arb1h",  5'b00010, 1'b1, 4'd14);
        pdone = 1'b1;
        step("arb1r",  5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        step("arb1i",  5'b00000, 1'b0, 4'd0);
        step("arb2",   5'b00100, 1'b1, 4'd15);
        pdone = 1'b1;
        step("arb2r",  5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        step("arb2i",  5'b00000, 1'b0, 4'd0);

        // Reset mid-grant: last=2, so channel 4 wins; reset clears without an edge.
        step("pre_rst", 5'b10000, 1'b1, 4'd15);
        #2;
        prstn = 1'b0;
        #1;
        check_val("arst.pgnt",     32'(pgnt),     32'd0);
        check_val("arst.pgnt_vld", 32'(pgnt_vld), 32'd0);
        check_val("arst.pbusy",    32'(pbusy),    32'd0);
        check_val("arst.pcnt",     32'(pcnt),     32'd0);
        @(negedge pclk);
        prstn = 1'b1;

        // Full round-robin after reset: 0,1,2,3,4,0 with a dead cycle between owners.
        preq = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            one_hot = 5'b00001 << (i % 5);
            step($sformatf("rr%0d", i), one_hot, 1'b1, 4'd15);
            pdone = 1'b1;
            step($sformatf("rr%0dr", i), 5'b00000, 1'b1, 4'd0);
            pdone = 1'b0;
            step($sformatf("rr%0di", i), 5'b00000, 1'b0, 4'd0);
        end

        // Winner request drop releases the grant (last=0, so channel 1 wins).
        preq = 5'b00110;
        step("drop",   5'b00010, 1'b1, 4'd15);
        preq = 5'b00100;
        step("dropr",  5'b00000, 1'b1, 4'd0);
        step("dropi",  5'b00000, 1'b0, 4'd0);
        step("drop2",  5'b00100, 1'b1, 4'd15);
        // Simultaneous pdone and request drop: one exit, last becomes 2.
        preq  = 5'b00000;
        pdone = 1'b1;
        step("simr",   5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        step("simi",   5'b00000, 1'b0, 4'd0);

        // Master enable low in IDLE blocks grants.
        preq = 5'b11111;
        pm   = 1'b0;
        step("pm0a",   5'b00000, 1'b0, 4'd0);
        step("pm0b",   5'b00000, 1'b0, 4'd0);
        // Enable falling mid-grant lets the grant continue (last=2 -> channel 3).
        pm = 1'b1;
        step("pmg",    5'b01000, 1'b1, 4'd15);
        pm = 1'b0;
        step("pmg_h",  5'b01000, 1'b1, 4'd14);
        pdone = 1'b1;
        step("pmg_r",  5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        step("pmg_i",  5'b00000, 1'b0, 4'd0);
        step("pmg_i2", 5'b00000, 1'b0, 4'd0);

        // pdone in IDLE is ignored: grant still issued (last=3 -> channel 0).
        pm    = 1'b1;
        preq  = 5'b00001;
        pdone = 1'b1;
        step("dn_idle", 5'b00001, 1'b1, 4'd15);
        step("dn_r",    5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        step("dn_i",    5'b00000, 1'b0, 4'd0);

        // Broadcast: masked multi-grant for one cycle, then two zero cycles.
        pi    = 1'b1;
        pk    = 1'b1;
        pq    = 1'b0;
        preq  = 5'b11111;
        pmask = 5'b01011;
        step("bc",     5'b01011, 1'b1, 4'd0);
        pm = 1'b0;
        step("bc_r",   5'b00000, 1'b1, 4'd0);
        step("bc_i",   5'b00000, 1'b0, 4'd0);
        // last unchanged by broadcast: still 0, so channel 1 wins next.
        pi = 1'b0;
        pm = 1'b1;
        step("bc_last", 5'b00010, 1'b1, 4'd15);
        pdone = 1'b1;
        step("bc_lr",   5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        pm    = 1'b0;
        step("bc_li",   5'b00000, 1'b0, 4'd0);

        // Broadcast mode with nothing permitted falls back to arbitration (last=1).
        pi    = 1'b1;
        pmask = 5'b00000;
        preq  = 5'b00100;
        pm    = 1'b1;
        step("bc_none",   5'b00100, 1'b1, 4'd15);
        pdone = 1'b1;
        step("bc_none_r", 5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        pm    = 1'b0;
        step("bc_none_i", 5'b00000, 1'b0, 4'd0);
        pi    = 1'b0;
        pmask = 5'b11111;

        // Hold counter behaviour (last=2 -> channel 3 with preq=01000).
        preq  = 5'b01000;
        phold = 4'd3;
        pm    = 1'b1;
        step("hold3a", 5'b01000, 1'b1, 4'd3);
        step("hold3b", 5'b01000, 1'b1, 4'd2);
        step("hold3c", 5'b01000, 1'b1, 4'd1);
`ifdef CC_CHAN_TIMEOUT_EN
        step("hold3r", 5'b00000, 1'b1, 4'd0);
        pm = 1'b0;
        step("hold3i", 5'b00000, 1'b0, 4'd0);
        // phold=0 gives exactly one grant cycle (last=3 -> channel 3 again).
        phold = 4'd0;
        pm    = 1'b1;
        step("hold0",  5'b01000, 1'b1, 4'd1);
        pm = 1'b0;
        step("hold0r", 5'b00000, 1'b1, 4'd0);
        step("hold0i", 5'b00000, 1'b0, 4'd0);
`else
        // Without timeout the grant persists; the counter saturates at 0.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("hold_p%0d", i), 5'b01000, 1'b1, 4'd0);
        end
        pdone = 1'b1;
        step("hold_r", 5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        pm    = 1'b0;
        step("hold_i", 5'b00000, 1'b0, 4'd0);
        // phold=0 loads 1 and then counts to 0 while the grant stays.
        phold = 4'd0;
        pm    = 1'b1;
        step("hold0",  5'b01000, 1'b1, 4'd1);
        step("hold0b", 5'b01000, 1'b1, 4'd0);
        pdone = 1'b1;
        step("hold0r", 5'b00000, 1'b1, 4'd0);
        pdone = 1'b0;
        step("hold0i", 5'b00000, 1'b0, 4'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
